// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 serial transmit/receive pair.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_MIN_CPB   = 2;

    // Common state encoding for the TX and RX frame FSMs.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: loadable down-counter producing half- and full-period ticks.
// Latency: full_tick every P cycles after load/resync; half_tick P/2 cycles after load/resync.
// Backpressure: none; free-running once loaded, owners ignore ticks they do not need.
//
// Ports: clk, resetn (async active-low); load latches a new period (clamped to
// UART_MIN_CPB) and restarts; resync restarts with the held period;
// half_tick / full_tick are single-cycle combinational strobes.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CPB_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 load,
    input  logic [CPB_WIDTH-1:0] period,
    input  logic                 resync,
    output logic                 half_tick,
    output logic                 full_tick
);

    localparam logic [CPB_WIDTH-1:0] MIN_P = CPB_WIDTH'(UART_MIN_CPB);
    localparam logic [CPB_WIDTH-1:0] ONE   = CPB_WIDTH'(1);

    logic [CPB_WIDTH-1:0] per_q, per_d;
    logic [CPB_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        per_d = per_q;
        cnt_d = cnt_q;
        if (load) begin
            per_d = (period < MIN_P) ? MIN_P : period;
            cnt_d = per_d - ONE;
        end else if (resync || (cnt_q == '0)) begin
            // Auto-reload so consecutive bits stay exactly P cycles apart.
            cnt_d = per_q - ONE;
        end else begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            per_q <= MIN_P;
            cnt_q <= '0;
        end else begin
            per_q <= per_d;
            cnt_q <= cnt_d;
        end
    end

    // Counter reads P-j on the j-th edge after a (re)start, so P - P/2 marks j = P/2.
    assign half_tick = (cnt_q == (per_q - (per_q >> 1)));
    assign full_tick = (cnt_q == '0);

endmodule

// File: rtl/uart_serdes.sv
// 8N1 serial transmitter and receiver sharing clock, reset and bit period.
// Latency: TX frame 10*P cycles from request; RX valid ~2 + P/2 + 9*P cycles after start edge.
// Backpressure: uart_tx_en is ignored while uart_tx_busy; RX has none (status is level, overwritten).
//
// Ports: clk, resetn (async active-low), cycles_per_bit (P, clamped to >= 2, latched per frame);
// TX: uart_tx_en, uart_tx_data -> uart_txd (idle high), uart_tx_busy;
// RX: uart_rxd (async), uart_rx_en -> uart_rx_valid, uart_rx_data, uart_rx_break.
// Build option: define UART_BREAK_DETECT_EN to report break frames on uart_rx_break;
// otherwise uart_rx_break stays 0 and break frames are dropped like framing errors.
module uart_serdes
    import uart_pkg::*;
#(
    parameter int CPB_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [CPB_WIDTH-1:0] cycles_per_bit,
    input  logic                 uart_tx_en,
    input  logic [7:0]           uart_tx_data,
    output logic                 uart_txd,
    output logic                 uart_tx_busy,
    input  logic                 uart_rxd,
    input  logic                 uart_rx_en,
    output logic                 uart_rx_valid,
    output logic [7:0]           uart_rx_data,
    output logic                 uart_rx_break
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    // ---------------- TX path ----------------
    uart_state_e tx_state_q, tx_state_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        txd_q, txd_d;
    logic        tx_load;
    logic        tx_full;

    uart_bit_timer #(.CPB_WIDTH(CPB_WIDTH)) u_tx_timer (
        .clk       (clk),
        .resetn    (resetn),
        .load      (tx_load),
        .period    (cycles_per_bit),
        .resync    (1'b0),
        .half_tick (),
        .full_tick (tx_full)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_idx_d   = tx_idx_q;
        tx_sh_d    = tx_sh_q;
        txd_d      = txd_q;
        tx_load    = 1'b0;
        unique case (tx_state_q)
            ST_IDLE: begin
                if (uart_tx_en) begin
                    tx_sh_d    = uart_tx_data;
                    tx_state_d = ST_START;
                    txd_d      = 1'b0;
                    tx_load    = 1'b1;
                end
            end
            ST_START: begin
                if (tx_full) begin
                    txd_d      = tx_sh_q[0];
                    tx_sh_d    = tx_sh_q >> 1;
                    tx_idx_d   = '0;
                    tx_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_full) begin
                    if (tx_idx_q == LAST_BIT) begin
                        txd_d      = 1'b1;
                        tx_state_d = ST_STOP;
                    end else begin
                        txd_d    = tx_sh_q[0];
                        tx_sh_d  = tx_sh_q >> 1;
                        tx_idx_d = tx_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tx_full) begin
                    // A request on the final stop edge chains the next frame with no gap.
                    if (uart_tx_en) begin
                        tx_sh_d    = uart_tx_data;
                        tx_state_d = ST_START;
                        txd_d      = 1'b0;
                        tx_load    = 1'b1;
                    end else begin
                        tx_state_d = ST_IDLE;
                        txd_d      = 1'b1;
                    end
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    // ---------------- RX path ----------------
    uart_state_e rx_state_q, rx_state_d;
    logic [2:0]  rx_idx_q, rx_idx_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_break_q, rx_break_d;
    logic        sync1_q, sync2_q, prev_q;
    logic        rx_fall;
    logic        rx_load, rx_resync;
    logic        rx_half, rx_full;

    uart_bit_timer #(.CPB_WIDTH(CPB_WIDTH)) u_rx_timer (
        .clk       (clk),
        .resetn    (resetn),
        .load      (rx_load),
        .period    (cycles_per_bit),
        .resync    (rx_resync),
        .half_tick (rx_half),
        .full_tick (rx_full)
    );

    // Re-arming after a break falls out of this: a held-low line yields no new falling edge.
    assign rx_fall = prev_q & ~sync2_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_idx_d   = rx_idx_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_break_d = rx_break_q;
        rx_load    = 1'b0;
        rx_resync  = 1'b0;
        if (!uart_rx_en) begin
            rx_state_d = ST_IDLE;
            rx_valid_d = 1'b0;
            rx_break_d = 1'b0;
        end else begin
            unique case (rx_state_q)
                ST_IDLE: begin
                    if (rx_fall) begin
                        rx_state_d = ST_START;
                        rx_load    = 1'b1;
                        rx_valid_d = 1'b0;
                        rx_break_d = 1'b0;
                    end
                end
                ST_START: begin
                    if (rx_half) begin
                        if (sync2_q) begin
                            rx_state_d = ST_IDLE;      // false start
                        end else begin
                            // Re-centre the timer so later samples land mid-bit.
                            rx_state_d = ST_DATA;
                            rx_idx_d   = '0;
                            rx_resync  = 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_full) begin
                        rx_sh_d = {sync2_q, rx_sh_q[7:1]};
                        if (rx_idx_q == LAST_BIT) begin
                            rx_state_d = ST_STOP;
                        end else begin
                            rx_idx_d = rx_idx_q + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (rx_full) begin
                        rx_state_d = ST_IDLE;
                        if (sync2_q) begin
                            rx_data_d  = rx_sh_q;
                            rx_valid_d = 1'b1;
                            rx_break_d = 1'b0;
                        end else if (rx_sh_q == '0) begin
`ifdef UART_BREAK_DETECT_EN
                            rx_break_d = 1'b1;
`else
                            rx_break_d = 1'b0;   // treated as a framing error
`endif
                        end
                    end
                end
                default: rx_state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state_q <= ST_IDLE;
            tx_idx_q   <= '0;
            tx_sh_q    <= '0;
            txd_q      <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_idx_q   <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_break_q <= 1'b0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_idx_q   <= tx_idx_d;
            tx_sh_q    <= tx_sh_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_idx_q   <= rx_idx_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_break_q <= rx_break_d;
            sync1_q    <= uart_rxd;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
        end
    end

    assign uart_txd      = txd_q;
    assign uart_tx_busy  = (tx_state_q != ST_IDLE);
    assign uart_rx_valid = rx_valid_q;
    assign uart_rx_data  = rx_data_q;
    assign uart_rx_break = rx_break_q;

endmodule

// File: tb/tb_uart_serdes.sv
// Directed bench for uart_serdes at P=16: TX waveform, back-to-back, loopback RX,
// glitch rejection, break handling and asynchronous reset mid-frame.
module tb_uart_serdes;

    localparam int P = 16;
`ifdef UART_BREAK_DETECT_EN
    localparam logic EXP_BRK = 1'b1;
`else
    localparam logic EXP_BRK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] cycles_per_bit;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        txd;
    logic        tx_busy;
    logic        rxd;
    logic        rx_en;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_break;
    logic        loop_en;
    logic        rxd_drv;

    int n_vec = 0;
    int n_err = 0;

    assign rxd = loop_en ? txd : rxd_drv;

    always #5 clk = ~clk;

    uart_serdes #(.CPB_WIDTH(32)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .cycles_per_bit (cycles_per_bit),
        .uart_tx_en     (tx_en),
        .uart_tx_data   (tx_data),
        .uart_txd       (txd),
        .uart_tx_busy   (tx_busy),
        .uart_rxd       (rxd),
        .uart_rx_en     (rx_en),
        .uart_rx_valid  (rx_valid),
        .uart_rx_data   (rx_data),
        .uart_rx_break  (rx_break)
    );

    // Expected line level for frame slot k (0 start, 1..8 data LSB first, 9 stop).
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Request a frame; returns #1 after the accepting edge.
    task automatic tx_start(input logic [7:0] b);
        @(negedge clk);
        tx_en   = 1'b1;
        tx_data = b;
        @(posedge clk);
        #1;
        tx_en   = 1'b0;
        tx_data = ~b;
    endtask

    task automatic wait_valid(input int limit, output int cyc);
        cyc = 0;
        while (rx_valid !== 1'b1 && cyc < limit) begin
            tick(1);
            cyc++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (tx_busy === 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        n_vec++;
        if ({txd, tx_busy, rx_valid, rx_break, rx_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL reset: txd=%b busy=%b valid=%b break=%b data=%h, want 1 0 0 0 00",
                     txd, tx_busy, rx_valid, rx_break, rx_data);
        end
        @(negedge clk);
        resetn = 1'b1;
        tick(3);
    endtask

    task automatic test_tx_a5();
        logic [7:0] b = 8'hA5;
        tx_start(b);
        for (int c = 0; c <= 10 * P; c++) begin
            logic eb, et;
            eb = (c < 10 * P);
            et = (c < 10 * P) ? frame_bit(b, c / P) : 1'b1;
            n_vec++;
            if (tx_busy !== eb || txd !== et) begin
                n_err++;
                $display("FAIL tx_a5 cycle %0d: busy=%b txd=%b, want busy=%b txd=%b", c, tx_busy, txd, eb, et);
            end
            tick(1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b0 = 8'h55;
        logic [7:0] b1 = 8'h0F;
        tx_start(b0);
        for (int c = 0; c <= 20 * P; c++) begin
            logic eb, et;
            eb = (c < 20 * P);
            if (c < 10 * P)      et = frame_bit(b0, c / P);
            else if (c < 20 * P) et = frame_bit(b1, (c - 10 * P) / P);
            else                 et = 1'b1;
            n_vec++;
            if (tx_busy !== eb || txd !== et) begin
                n_err++;
                $display("FAIL back_to_back cycle %0d: busy=%b txd=%b, want busy=%b txd=%b", c, tx_busy, txd, eb, et);
            end
            // Mid-frame request must be ignored; the one before the busy-fall edge is chained.
            if (c == 40)          begin tx_en = 1'b1; tx_data = 8'hFF; end
            if (c == 41)          begin tx_en = 1'b0; tx_data = 8'h00; end
            if (c == 10 * P - 1)  begin tx_en = 1'b1; tx_data = b1;    end
            if (c == 10 * P)      begin tx_en = 1'b0; tx_data = 8'h00; end
            tick(1);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h3C};
        int cyc;
        loop_en = 1'b1;
        rx_en   = 1'b1;
        tick(5);
        for (int i = 0; i < 3; i++) begin
            tx_start(bytes[i]);
            tick(10);
            n_vec++;
            if (rx_valid !== 1'b0) begin
                n_err++;
                $display("FAIL loop_valid_clear byte %h: valid=%b, want 0", bytes[i], rx_valid);
            end
            wait_valid(400, cyc);
            cyc += 10;
            n_vec++;
            if (rx_valid !== 1'b1 || cyc < 150 || cyc > 158 || rx_data !== bytes[i]) begin
                n_err++;
                $display("FAIL loop_rx byte %h: valid=%b data=%h after %0d cycles, want valid=1 data=%h within 150..158",
                         bytes[i], rx_valid, rx_data, cyc, bytes[i]);
            end
            wait_idle();
            tick(4);
        end
    endtask

    task automatic test_glitch();
        int cyc;
        loop_en = 1'b0;
        rxd_drv = 1'b1;
        @(negedge clk);
        rx_en = 1'b0;
        tick(1);
        n_vec++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h3C) begin
            n_err++;
            $display("FAIL rx_en_low: valid=%b data=%h, want valid=0 data=3c", rx_valid, rx_data);
        end
        rx_en = 1'b1;
        tick(5);
        rxd_drv = 1'b0;
        tick(4);
        rxd_drv = 1'b1;
        tick(40);
        n_vec++;
        if (rx_valid !== 1'b0 || rx_break !== 1'b0) begin
            n_err++;
            $display("FAIL glitch: valid=%b break=%b, want 0 0", rx_valid, rx_break);
        end
        // Receiver must be back in IDLE and able to take a real frame.
        loop_en = 1'b1;
        tx_start(8'h96);
        wait_valid(400, cyc);
        n_vec++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h96) begin
            n_err++;
            $display("FAIL glitch_recover: valid=%b data=%h, want 1 96", rx_valid, rx_data);
        end
        wait_idle();
        tick(4);
    endtask

    task automatic test_break();
        loop_en = 1'b0;
        rxd_drv = 1'b1;
        tick(2);
        rxd_drv = 1'b0;
        tick(12 * P);
        rxd_drv = 1'b1;
        tick(20);
        n_vec++;
        if (rx_break !== EXP_BRK || rx_valid !== 1'b0 || rx_data !== 8'h96) begin
            n_err++;
            $display("FAIL break: break=%b valid=%b data=%h, want break=%b valid=0 data=96",
                     rx_break, rx_valid, rx_data, EXP_BRK);
        end
        @(negedge clk);
        rx_en = 1'b0;
        tick(1);
        n_vec++;
        if (rx_break !== 1'b0) begin
            n_err++;
            $display("FAIL break_clear: break=%b, want 0", rx_break);
        end
        rx_en = 1'b1;
        tick(2);
    endtask

    task automatic test_reset_mid();
        int cyc;
        loop_en = 1'b1;
        tx_start(8'hA5);
        tick(40);
        n_vec++;
        if (txd !== 1'b0 || tx_busy !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: txd=%b busy=%b, want 0 1", txd, tx_busy);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_vec++;
        if ({txd, tx_busy, rx_valid, rx_break, rx_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL reset_mid: txd=%b busy=%b valid=%b break=%b data=%h, want 1 0 0 0 00",
                     txd, tx_busy, rx_valid, rx_break, rx_data);
        end
        @(negedge clk);
        resetn = 1'b1;
        tick(5);
        tx_start(8'hC3);
        wait_valid(400, cyc);
        n_vec++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hC3 || cyc < 150 || cyc > 158) begin
            n_err++;
            $display("FAIL post_reset_frame: valid=%b data=%h after %0d cycles, want 1 c3 within 150..158",
                     rx_valid, rx_data, cyc);
        end
        wait_idle();
        n_vec++;
        if (tx_busy !== 1'b0 || txd !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_idle: busy=%b txd=%b, want 0 1", tx_busy, txd);
        end
    endtask

    initial begin
        resetn         = 1'b0;
        cycles_per_bit = 32'(P);
        tx_en          = 1'b0;
        tx_data        = 8'h00;
        rx_en          = 1'b0;
        loop_en        = 1'b0;
        rxd_drv        = 1'b1;
        test_reset();
        test_tx_a5();
        test_back_to_back();
        test_loopback();
        test_glitch();
        test_break();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_serdes.md
# uart_serdes

- Byte-level serial transmitter/receiver pair for 8N1 asynchronous serial: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit.
- Sits under the memory-mapped UART peripheral, which supplies the enables, transmit data and runtime bit period, and reads back data and status.
- Transmit and receive paths are independent and share only clock, reset and `cycles_per_bit`.

## Interface
- `CPB_WIDTH`, default 32: width of the `cycles_per_bit` input.
- `clk`, input, 1: single system clock, rising edge.
- `resetn`, input, 1: asynchronous, active-low reset.
- `cycles_per_bit`, input, CPB_WIDTH: bit period in clk cycles.
- `uart_tx_en`, input, 1: transmit request.
- `uart_tx_data`, input, 8: byte to send.
- `uart_txd`, output, 1: serial output, idle high.
- `uart_tx_busy`, output, 1: a frame is in progress.
- `uart_rxd`, input, 1: serial input, asynchronous to clk.
- `uart_rx_en`, input, 1: receiver enable.
- `uart_rx_valid`, output, 1: a received byte is available.
- `uart_rx_data`, output, 8: last received byte.
- `uart_rx_break`, output, 1: break condition detected.

## Operation
- Bit period P = `cycles_per_bit`; any value below 2 is treated as 2. P is latched at frame start, so a mid-frame change takes effect on the next frame.
- TX FSM states: IDLE, START, DATA (bit index 0..7), STOP.
  - In IDLE, `uart_tx_en`=1 latches `uart_tx_data` and moves to START.
  - START, each DATA bit and STOP each last exactly P cycles; STOP returns to IDLE.
  - `uart_tx_en` while busy is ignored; the latched byte is not altered.
- RX path: `uart_rxd` passes through a 2-flop synchronizer.
- RX FSM states: IDLE, START, DATA, STOP.
  - In IDLE with `uart_rx_en`=1, a high-to-low transition on the synchronized input enters START.
  - The start bit is sampled at P/2 (integer divide). If it reads high, this is a false start: return to IDLE with no status change.
  - Each data bit and the stop bit are then sampled every P cycles thereafter, shifting LSB first.
- Stop sample = 1: load `uart_rx_data`, set `uart_rx_valid`, clear `uart_rx_break`.
- Stop sample = 0 and all data bits = 0: set `uart_rx_break`, leave `uart_rx_data` and `uart_rx_valid` unchanged.
- Stop sample = 0 otherwise: framing error; drop the frame with no status change.
- After a break, the receiver waits for the line to return high before re-arming.
- `uart_rx_valid` and `uart_rx_break` are levels. Both clear on the next start-bit detection, or while `uart_rx_en`=0.
- `uart_rx_en` going low forces the RX FSM to IDLE immediately. `uart_rx_data` keeps its last value.

## Timing
- Reset values:
  - `uart_txd`=1, `uart_tx_busy`=0.
  - `uart_rx_valid`=0, `uart_rx_break`=0, `uart_rx_data`=0.
  - Both FSMs in IDLE.
- Reset asserted mid-frame aborts the frame immediately; `uart_txd` returns high asynchronously.
- TX, request sampled on edge N:
  - `uart_tx_busy`=1 and `uart_txd`=0 from N+1.
  - Frame lasts 10·P cycles; `uart_tx_busy` falls at N+1+10·P.
  - A request on that same edge is accepted, giving back-to-back frames with no idle gap.
- RX: `uart_rx_valid` rises one cycle after the mid-stop-bit sample, about 2 + P/2 + 9·P cycles after the falling edge of the start bit on `uart_rxd`.

## Configuration
- `UART_BREAK_DETECT_EN`
  - Defined: break detection as described above.
  - Undefined: `uart_rx_break` is tied 0, and a break frame is handled as an ordinary framing error (dropped).

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP).
  - `UART_DATA_BITS`=8.
  - `UART_MIN_CPB`=2.
- Sub-module `uart_bit_timer`, instantiated once per path:
  - Loadable down-counter of CPB_WIDTH bits.
  - Half-period and full-period tick outputs.

## Test plan
- TX, P=16, request with byte 0xA5:
  - `uart_txd` shows 0, 1,0,1,0,0,1,0,1, 1, each bit 16 cycles.
  - `uart_tx_busy` is high for exactly 160 cycles.
- TX back-to-back, 0x55 then 0x0F: second request issued while busy is ignored; request on the busy-fall edge starts the next frame with no idle gap.
- RX loopback (`uart_txd` → `uart_rxd`), P=16, bytes 0x00, 0xFF, 0x3C: each sets `uart_rx_valid`=1 with matching `uart_rx_data`; valid clears at the next start bit.
- RX glitch, P=16: 4-cycle low pulse on idle line → no valid, no break, FSM back in IDLE.
- RX break, P=16, line held low for 12·P:
  - With `UART_BREAK_DETECT_EN`: `uart_rx_break`=1, `uart_rx_valid` unchanged.
  - Without the macro: nothing is reported.
- `resetn` pulsed low mid-TX and mid-RX frame:
  - `uart_txd`=1 and `uart_tx_busy`=0 immediately.
  - RX status cleared.
  - The next full frame works normally.
